// File: rtl/midi_msg_parser_if.sv
// Byte-stream input and note-event output bundle of the MIDI message parser.
// master = byte source / event consumer side, slave = the parser itself.
interface midi_msg_parser_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       ev_valid;
    logic       ev_on;
    logic [3:0] ev_chan;
    logic [6:0] ev_note;
    logic [6:0] ev_vel;
    logic       note_active;
    logic [6:0] note_held;
    logic       err_stray;

    modport master (
        output byte_in, byte_valid,
        input  ev_valid, ev_on, ev_chan, ev_note, ev_vel,
        input  note_active, note_held, err_stray
    );

    modport slave (
        input  byte_in, byte_valid,
        output ev_valid, ev_on, ev_chan, ev_note, ev_vel,
        output note_active, note_held, err_stray
    );
endinterface

// File: rtl/midi_msg_parser.sv
// MIDI channel-voice parser with running status, note events and held-note tracking.
// Optional macro CHANNEL_FILTER_EN: only messages on channel CHANNEL produce events.
module midi_msg_parser #(
    parameter logic [3:0] CHANNEL = 4'd0
) (
    input  logic                  clk,
    input  logic                  rst,
    midi_msg_parser_if.slave      bus
);

    typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SYSEX} state_t;

    state_t     state;
    logic       rs_valid;
    logic [3:0] rs_type;
    logic [3:0] rs_chan;
    logic [6:0] d1;

    logic       one_byte;
    logic       chan_ok;
    logic       note_msg;
    logic       note_on;

    always_comb begin
        one_byte = (rs_type == 4'hC) || (rs_type == 4'hD);
`ifdef CHANNEL_FILTER_EN
        chan_ok  = (rs_chan == CHANNEL);
`else
        chan_ok  = 1'b1;
`endif
        note_msg = ((rs_type == 4'h8) || (rs_type == 4'h9)) && chan_ok;
        // velocity 0 on a note-on is a note-off
        note_on  = (rs_type == 4'h9) && (bus.byte_in[6:0] != 7'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            rs_valid        <= 1'b0;
            rs_type         <= '0;
            rs_chan         <= '0;
            d1              <= '0;
            bus.ev_valid    <= 1'b0;
            bus.ev_on       <= 1'b0;
            bus.ev_chan     <= '0;
            bus.ev_note     <= '0;
            bus.ev_vel      <= '0;
            bus.note_active <= 1'b0;
            bus.note_held   <= '0;
            bus.err_stray   <= 1'b0;
        end else begin
            bus.ev_valid  <= 1'b0;
            bus.err_stray <= 1'b0;
            if (bus.byte_valid) begin
                if (bus.byte_in[7:3] == 5'b11111) begin
                    // real-time: transparent to parsing
                end else if (bus.byte_in[7:4] == 4'hF) begin
                    rs_valid <= 1'b0;
                    state    <= (bus.byte_in == 8'hF0) ? SYSEX : IDLE;
                end else if (bus.byte_in[7]) begin
                    rs_valid <= 1'b1;
                    rs_type  <= bus.byte_in[7:4];
                    rs_chan  <= bus.byte_in[3:0];
                    state    <= WAIT_D1;
                end else begin
                    case (state)
                        IDLE, WAIT_D1: begin
                            if (state == WAIT_D1 || rs_valid) begin
                                d1    <= bus.byte_in[6:0];
                                state <= one_byte ? IDLE : WAIT_D2;
                            end else begin
                                bus.err_stray <= 1'b1;
                            end
                        end
                        WAIT_D2: begin
                            state <= IDLE;
                            if (note_msg) begin
                                bus.ev_valid <= 1'b1;
                                bus.ev_on    <= note_on;
                                bus.ev_chan  <= rs_chan;
                                bus.ev_note  <= d1;
                                bus.ev_vel   <= note_on ? bus.byte_in[6:0] : '0;
                                if (note_on) begin
                                    bus.note_held   <= d1;
                                    bus.note_active <= 1'b1;
                                end else if (d1 == bus.note_held) begin
                                    bus.note_active <= 1'b0;
                                end
                            end
                        end
                        default: begin
                            // SYSEX payload is dropped silently
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_midi_msg_parser.sv
// Self-checking bench for midi_msg_parser: directed scenarios plus randomized byte
// streams checked against a message-level reference model.
module tb_midi_msg_parser;

    localparam logic [3:0] TB_CHAN = 4'd2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    midi_msg_parser_if bus ();

    midi_msg_parser #(.CHANNEL(TB_CHAN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // reference model: running status byte, collected data bytes, sysex flag
    bit         m_rs;
    logic [7:0] m_status;
    bit         m_sysex;
    int         m_cnt;
    logic [6:0] m_d [2];
    logic       m_ev, m_on, m_act, m_err;
    logic [3:0] m_chan;
    logic [6:0] m_note, m_vel, m_held;

    task automatic model_reset();
        m_rs = 0; m_status = '0; m_sysex = 0; m_cnt = 0;
        m_ev = 0; m_on = 0; m_act = 0; m_err = 0;
        m_chan = '0; m_note = '0; m_vel = '0; m_held = '0;
    endtask

    task automatic model_step(input logic [7:0] b);
        int  need;
        bit  chan_ok;
        m_ev  = 0;
        m_err = 0;
        if (b >= 8'hF8) begin
        end else if (b >= 8'hF0) begin
            m_rs = 0; m_cnt = 0; m_sysex = (b == 8'hF0);
        end else if (b >= 8'h80) begin
            m_rs = 1; m_status = b; m_cnt = 0; m_sysex = 0;
        end else if (m_sysex) begin
        end else if (!m_rs) begin
            m_err = 1;
        end else begin
            m_d[m_cnt] = b[6:0];
            m_cnt = m_cnt + 1;
            need = (m_status[7:4] == 4'hC || m_status[7:4] == 4'hD) ? 1 : 2;
            if (m_cnt == need) begin
                m_cnt = 0;
`ifdef CHANNEL_FILTER_EN
                chan_ok = (m_status[3:0] == TB_CHAN);
`else
                chan_ok = 1;
`endif
                if (need == 2 && chan_ok && (m_status[7:4] == 4'h8 || m_status[7:4] == 4'h9)) begin
                    m_ev   = 1;
                    m_on   = (m_status[7:4] == 4'h9) && (m_d[1] != 0);
                    m_chan = m_status[3:0];
                    m_note = m_d[0];
                    m_vel  = m_on ? m_d[1] : 7'd0;
                    if (m_on) begin
                        m_held = m_d[0];
                        m_act  = 1;
                    end else if (m_d[0] == m_held) begin
                        m_act = 0;
                    end
                end
            end
        end
    endtask

    function automatic logic [28:0] obs();
        return {bus.ev_valid, bus.ev_on, bus.ev_chan, bus.ev_note, bus.ev_vel,
                bus.note_active, bus.note_held, bus.err_stray};
    endfunction

    function automatic logic [28:0] expv();
        return {m_ev, m_on, m_chan, m_note, m_vel, m_act, m_held, m_err};
    endfunction

    // drive one strobe; returns at posedge+1 with outputs of that edge visible
    task automatic send_byte(input logic [7:0] b);
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
        model_step(b);
    endtask

    task automatic test_reset();
        bus.byte_in = '0;
        bus.byte_valid = 1'b0;
        rst = 1'b1;
        model_reset();
        #12;
        n_cmp++;
        if (obs() !== 29'd0) begin
            n_err++;
            $display("FAIL reset_state: got %h expected %h", obs(), 29'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic run_seq(input string name, input logic [7:0] seq[$]);
        foreach (seq[i]) begin
            send_byte(seq[i]);
            n_cmp++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL %s byte %0d (%h): got %h expected %h", name, i, seq[i], obs(), expv());
            end
        end
    endtask

    task automatic test_note_on();
        run_seq("note_on", '{8'h90, 8'h3C, 8'h64});
        n_cmp++;
        if (obs() !== {1'b1, 1'b1, 4'd0, 7'h3C, 7'h64, 1'b1, 7'h3C, 1'b0}) begin
            n_err++;
            $display("FAIL note_on_fields: got %h expected %h", obs(),
                     {1'b1, 1'b1, 4'd0, 7'h3C, 7'h64, 1'b1, 7'h3C, 1'b0});
        end
    endtask

    task automatic test_running_status();
        run_seq("running_status", '{8'h91, 8'h40, 8'h50, 8'h40, 8'h00});
        n_cmp++;
        if (obs() !== {1'b1, 1'b0, 4'd1, 7'h40, 7'h00, 1'b0, 7'h40, 1'b0}) begin
            n_err++;
            $display("FAIL running_status_off: got %h expected %h", obs(),
                     {1'b1, 1'b0, 4'd1, 7'h40, 7'h00, 1'b0, 7'h40, 1'b0});
        end
    endtask

    task automatic test_realtime();
        run_seq("realtime", '{8'h90, 8'hF8, 8'h3C, 8'hFE, 8'h7F});
        n_cmp++;
        if ({bus.ev_valid, bus.ev_on, bus.ev_note, bus.ev_vel} !== {1'b1, 1'b1, 7'h3C, 7'h7F}) begin
            n_err++;
            $display("FAIL realtime_event: got %h expected %h",
                     {bus.ev_valid, bus.ev_on, bus.ev_note, bus.ev_vel}, {1'b1, 1'b1, 7'h3C, 7'h7F});
        end
    endtask

    task automatic test_stray_sysex();
        test_reset();
        run_seq("stray_sysex", '{8'h3C, 8'hF0, 8'h12, 8'h34, 8'hF7, 8'h40});
        n_cmp++;
        if ({bus.err_stray, bus.ev_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL stray_after_sysex: got %b expected %b", {bus.err_stray, bus.ev_valid}, 2'b10);
        end
    endtask

    task automatic test_mixed_and_reset();
        run_seq("mixed", '{8'hC0, 8'h05, 8'hB0, 8'h07, 8'h64, 8'h80, 8'h3C, 8'h40});
        run_seq("reset_mid_msg", '{8'h90});
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (obs() !== 29'd0) begin
            n_err++;
            $display("FAIL reset_mid_msg: got %h expected %h", obs(), 29'd0);
        end
        #1 rst = 1'b0;
        model_reset();
        run_seq("after_reset", '{8'h3C});
        n_cmp++;
        if (bus.err_stray !== 1'b1) begin
            n_err++;
            $display("FAIL after_reset_stray: got %b expected 1", bus.err_stray);
        end
    endtask

    task automatic test_channel_filter();
        run_seq("chan_other", '{8'h93, 8'h3C, 8'h64});
        run_seq("chan_match", '{8'h92, 8'h3C, 8'h64});
        n_cmp++;
        if ({bus.ev_valid, bus.ev_chan} !== {1'b1, 4'd2}) begin
            n_err++;
            $display("FAIL chan_match_chan: got %h expected %h", {bus.ev_valid, bus.ev_chan}, {1'b1, 4'd2});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        int         r;
        logic [6:0] notes [4];
        notes = '{7'h3C, 7'h40, 7'h43, 7'h00};
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 50) begin
                b = ($urandom_range(0, 3) == 0) ? 8'h00 : {1'b0, notes[$urandom_range(0, 2)]};
                if ($urandom_range(0, 4) == 0) b = {1'b0, 7'($urandom_range(0, 127))};
            end else if (r < 75) begin
                b = {4'($urandom_range(8, 14)), 4'($urandom_range(1, 3))};
            end else if (r < 88) begin
                b = 8'($urandom_range(248, 255));
            end else begin
                b = ($urandom_range(0, 1) == 0) ? 8'hF0 : 8'($urandom_range(240, 247));
            end
            send_byte(b);
            n_cmp++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL random byte %0d (%h): got %h expected %h", i, b, obs(), expv());
            end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
                m_ev  = 0;
                m_err = 0;
                n_cmp++;
                if (obs() !== expv()) begin
                    n_err++;
                    $display("FAIL random_gap %0d: got %h expected %h", i, obs(), expv());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_note_on();
        test_running_status();
        test_realtime();
        test_stray_sysex();
        test_mixed_and_reset();
        test_channel_filter();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
